// File: rtl/processor_control.sv
// processor_control: instruction sequencing FSM for the 9-bit processor datapath.
// It captures an instruction word from Din and steps the bus selects, register
// enables, ALU controls and FPU handshake through the instruction's transfer steps.
// The optional macro FP_TIMEOUT_EN adds an FWAIT watchdog. It aborts to IDLE after
// FP_TIMEOUT cycles without FPdone and sets a sticky Err flag. When the macro is
// undefined, FWAIT waits for FPdone indefinitely and Err is tied low.
// Outputs decode from the registered state and IR. They are held low while Reset
// is high, so an interrupted instruction never completes a write or pulses Done.
module processor_control #(
    parameter int FP_TIMEOUT = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Run,
    input  logic [8:0] Din,
    input  logic       FPdone,
    output logic       R0out,
    output logic       R1out,
    output logic       R2out,
    output logic       R3out,
    output logic       R4out,
    output logic       R5out,
    output logic       R6out,
    output logic       R7out,
    output logic       Gout,
    output logic       GFout,
    output logic       Dinout,
    output logic [7:0] Rin,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       FPstart,
    output logic [1:0] FPop,
    output logic       Done,
    output logic       Busy,
    output logic       Err
);

    typedef enum logic [2:0] {IDLE, T1, T2, FWAIT, T3} state_t;

    state_t     state;
    state_t     nstate;
    logic [8:0] ir;
    logic [2:0] op;
    logic [7:0] xsel;
    logic [7:0] ysel;
    logic [7:0] rout;
    logic       isfp;

    assign op   = ir[8:6];
    assign xsel = 8'b1 << ir[5:3];
    assign ysel = 8'b1 << ir[2:0];
    assign isfp = op[2] && (op != 3'b111);

    assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = rout;

`ifdef FP_TIMEOUT_EN
    localparam int CW = $clog2(FP_TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          timeout;
    logic          err;
`endif

    // State register and instruction capture; IR loads only on an accepted Run in IDLE
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && Run) begin
                ir <= Din;
            end
        end
    end

    // Next-state and output decode from state and IR; everything stays low during Reset
    always_comb begin
        nstate  = state;
        rout    = '0;
        Gout    = 1'b0;
        GFout   = 1'b0;
        Dinout  = 1'b0;
        Rin     = '0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        AddSub  = 1'b0;
        FPstart = 1'b0;
        FPop    = 2'b00;
        Done    = 1'b0;
        Busy    = 1'b0;
`ifdef FP_TIMEOUT_EN
        timeout = 1'b0;
`endif
        if (!Reset) begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        nstate = T1;
                    end
                end
                T1: begin
                    Busy = 1'b1;
                    case (op)
                        3'b000: begin
                            rout   = ysel;
                            Rin    = xsel;
                            Done   = 1'b1;
                            nstate = IDLE;
                        end
                        3'b001: begin
                            Dinout = 1'b1;
                            Rin    = xsel;
                            Done   = 1'b1;
                            nstate = IDLE;
                        end
                        3'b111: begin
                            Done   = 1'b1;
                            nstate = IDLE;
                        end
                        default: begin
                            rout   = xsel;
                            Ain    = 1'b1;
                            nstate = T2;
                        end
                    endcase
                end
                T2: begin
                    Busy = 1'b1;
                    rout = ysel;
                    if (isfp) begin
                        FPstart = 1'b1;
                        FPop    = ir[7:6];
                        nstate  = FWAIT;
                    end else begin
                        Gin    = 1'b1;
                        AddSub = op[0];
                        nstate = T3;
                    end
                end
                FWAIT: begin
                    Busy = 1'b1;
                    FPop = ir[7:6];
                    if (FPdone) begin
                        nstate = T3;
                    end
`ifdef FP_TIMEOUT_EN
                    else if (cnt == CW'(FP_TIMEOUT - 1)) begin
                        timeout = 1'b1;
                        nstate  = IDLE;
                    end
`endif
                end
                T3: begin
                    Busy   = 1'b1;
                    Rin    = xsel;
                    Done   = 1'b1;
                    nstate = IDLE;
                    if (isfp) begin
                        GFout = 1'b1;
                        FPop  = ir[7:6];
                    end else begin
                        Gout = 1'b1;
                    end
                end
                default: begin
                    nstate = IDLE;
                end
            endcase
        end
    end

`ifdef FP_TIMEOUT_EN
    // FWAIT cycle counter plus sticky error flag that only Reset clears
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == FWAIT) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    assign Err = err;
`else
    localparam int unused_fp_timeout = FP_TIMEOUT;

    assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_processor_control.sv
// tb_processor_control: scoreboard bench for processor_control.
// Expected output vectors are pushed when an instruction is launched. They are
// popped and compared one per cycle, #1 after each rising edge.
// Compile with FP_TIMEOUT_EN defined to also exercise the FWAIT watchdog.
module tb_processor_control;

    localparam int Timeout = 8;

    logic       Clock;
    logic       Reset;
    logic       Run;
    logic [8:0] Din;
    logic       FPdone;
    logic       R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
    logic       Gout, GFout, Dinout;
    logic [7:0] Rin;
    logic       Ain, Gin, AddSub, FPstart;
    logic [1:0] FPop;
    logic       Done, Busy, Err;

    logic [26:0] outVec;
    logic [10:0] selVec;
    logic [26:0] sb[$];
    logic        errExp;
    int          nVectors;
    int          nMiscompares;

    processor_control #(.FP_TIMEOUT(Timeout)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Din(Din), .FPdone(FPdone),
        .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
        .Gout(Gout), .GFout(GFout), .Dinout(Dinout), .Rin(Rin),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .FPstart(FPstart),
        .FPop(FPop), .Done(Done), .Busy(Busy), .Err(Err)
    );

    assign outVec = {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out,
                     Gout, GFout, Dinout, Rin, Ain, Gin, AddSub, FPstart, FPop, Done, Busy};
    assign selVec = {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out,
                     Gout, GFout, Dinout};

    // Free-running clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [26:0] mk(input logic [7:0] rsel, input logic g, input logic gf,
                                       input logic dino, input logic [7:0] rin, input logic ain,
                                       input logic gin, input logic addsub, input logic fpstart,
                                       input logic [1:0] fpop, input logic done, input logic busy);
        return {rsel, g, gf, dino, rin, ain, gin, addsub, fpstart, fpop, done, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [26:0] observed, input logic [26:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", tag, $time, observed, expected);
        end
    endtask

    // One clock: compare against the next scoreboard entry, plus bus-select and Err checks
    task automatic stepCycle();
        logic [26:0] e;
        @(posedge Clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("outputs", outVec, e);
        end
        checkOutput("onehot", {26'b0, ($countones(selVec) <= 1)}, 27'd1);
        checkOutput("err", {26'b0, Err}, {26'b0, errExp});
    endtask

    // Reference decode of one instruction into per-cycle expected output vectors
    task automatic pushExpect(input logic [8:0] instr, input int w, input bit withT3);
        logic [2:0] op;
        logic [7:0] xs;
        logic [7:0] ys;
        op = instr[8:6];
        xs = 8'b1 << instr[5:3];
        ys = 8'b1 << instr[2:0];
        case (op)
            3'b000: sb.push_back(mk(ys, 0, 0, 0, xs, 0, 0, 0, 0, 2'b00, 1, 1));
            3'b001: sb.push_back(mk(8'h00, 0, 0, 1, xs, 0, 0, 0, 0, 2'b00, 1, 1));
            3'b111: sb.push_back(mk(8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1));
            3'b010, 3'b011: begin
                sb.push_back(mk(xs, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00, 0, 1));
                sb.push_back(mk(ys, 0, 0, 0, 8'h00, 0, 1, op[0], 0, 2'b00, 0, 1));
                sb.push_back(mk(8'h00, 1, 0, 0, xs, 0, 0, 0, 0, 2'b00, 1, 1));
            end
            default: begin
                sb.push_back(mk(xs, 0, 0, 0, 8'h00, 1, 0, 0, 0, 2'b00, 0, 1));
                sb.push_back(mk(ys, 0, 0, 0, 8'h00, 0, 0, 0, 1, op[1:0], 0, 1));
                for (int i = 0; i < w; i++) begin
                    sb.push_back(mk(8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0, op[1:0], 0, 1));
                end
                if (withT3) begin
                    sb.push_back(mk(8'h00, 0, 1, 0, xs, 0, 0, 0, 0, op[1:0], 1, 1));
                end
            end
        endcase
    endtask

    // Launch one instruction from IDLE and run it to the following IDLE cycle
    task automatic applyStimulus(input logic [8:0] instr, input logic [8:0] imm, input int w,
                                 input bit giveDone, input bit spurT2);
        int  n;
        bit  isFp;
        isFp = instr[8] && (instr[8:6] != 3'b111);
        pushExpect(instr, w, giveDone);
        sb.push_back('0);
        Run = 1'b1;
        Din = instr;
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            stepCycle();
            Run    = 1'b0;
            Din    = imm;
            FPdone = (isFp && giveDone && k == 2 + w) || (spurT2 && k == 2);
            if (isFp && !giveDone && k == 2 + w) begin
                errExp = 1'b1;
            end
        end
        FPdone = 1'b0;
    endtask

    // Test sequence
    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        errExp       = 1'b0;
        Reset        = 1'b1;
        Run          = 1'b0;
        Din          = '0;
        FPdone       = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput("reset", outVec, '0);
        checkOutput("reset_err", {26'b0, Err}, 27'd0);
        Reset = 1'b0;
        stepCycle();

        applyStimulus(9'b001_011_000, 9'h0A5, 0, 1, 0);
        applyStimulus(9'b010_001_010, 9'h000, 0, 1, 0);
        applyStimulus(9'b011_001_010, 9'h000, 0, 1, 0);
        applyStimulus(9'b000_101_110, 9'h000, 0, 1, 0);
        applyStimulus(9'b111_000_000, 9'h000, 0, 1, 0);
        applyStimulus(9'b010_100_100, 9'h000, 0, 1, 0);
        applyStimulus(9'b110_011_100, 9'h000, 5, 1, 0);
        applyStimulus(9'b100_010_010, 9'h000, 1, 1, 1);
        applyStimulus(9'b101_111_000, 9'h000, 3, 1, 0);

        // Run held high through two add instructions: one accept per IDLE visit
        pushExpect(9'b010_100_001, 0, 1);
        sb.push_back('0);
        pushExpect(9'b010_100_001, 0, 1);
        sb.push_back('0);
        sb.push_back('0);
        Run = 1'b1;
        Din = 9'b010_100_001;
        for (int k = 1; k <= 9; k++) begin
            stepCycle();
            if (k == 7) begin
                Run = 1'b0;
            end
        end

        // Reset while in FWAIT, then a late FPdone that must have no effect
        pushExpect(9'b100_001_010, 2, 0);
        Run = 1'b1;
        Din = 9'b100_001_010;
        for (int k = 1; k <= 4; k++) begin
            stepCycle();
            Run = 1'b0;
        end
        Reset = 1'b1;
        sb.push_back('0);
        stepCycle();
        Reset  = 1'b0;
        FPdone = 1'b1;
        sb.push_back('0);
        stepCycle();
        FPdone = 1'b0;
        sb.push_back('0);
        stepCycle();
        sb.push_back('0);
        stepCycle();

`ifdef FP_TIMEOUT_EN
        // FPU never answers: watchdog aborts with no write or Done and sets Err
        applyStimulus(9'b110_011_100, 9'h000, Timeout, 0, 0);
        stepCycle();
`endif

        if (sb.size() != 0) begin
            nMiscompares++;
            $display("[TB] FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
